// File: rtl/rf_wport_arb.sv
// Register-file write-port arbiter: pipeline writeback vs. a 2-entry MDU result queue.
// Optional queue forwarding lookup is enabled by defining RF_ARB_FWD_EN.
module rf_wport_arb #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_rd,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    output logic        rf_wr,
    output logic [4:0]  rf_wr_reg,
    output logic [31:0] rf_wr_data,
    output logic        wb_stall,
    output logic [1:0]  pend_count,
    input  logic [4:0]  fwd_rs,
    output logic        fwd_hit,
    output logic [31:0] fwd_data
);

    localparam logic [4:0] SMAX = 5'(STARVE_MAX);

    logic [4:0]  q_rd   [2];
    logic [31:0] q_data [2];
    logic [1:0]  q_live;
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;
    logic [3:0]  starve;
    logic        stall_q;
    logic        popped_q;

    logic push;
    logic pop;
    logic wb_grant;
    logic head_live;
    logic starve_hit;

    assign mdu_ready  = (count < 2'd2);
    assign pend_count = count;
    assign wb_stall   = stall_q;

    assign push      = mdu_valid && mdu_ready;
    assign wb_grant  = !stall_q && wb_valid && (wb_rd != 5'd0);
    assign pop       = !wb_grant && (count != 2'd0);
    assign head_live = q_live[rd_ptr];

    // A lost arbitration that brings the counter up to STARVE_MAX.
    assign starve_hit = (count != 2'd0) && !pop
                     && (starve != 4'hF)
                     && (({1'b0, starve} + 5'd1) == SMAX);

    always_comb begin
        rf_wr      = 1'b0;
        rf_wr_reg  = 5'd0;
        rf_wr_data = 32'd0;
        unique case (1'b1)
            wb_grant: begin
                rf_wr      = 1'b1;
                rf_wr_reg  = wb_rd;
                rf_wr_data = wb_data;
            end
            pop && head_live: begin
                rf_wr      = 1'b1;
                rf_wr_reg  = q_rd[rd_ptr];
                rf_wr_data = q_data[rd_ptr];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wr_ptr]   <= mdu_rd;
            q_data[wr_ptr] <= mdu_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_live   <= 2'b00;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
            starve   <= 4'd0;
            stall_q  <= 1'b0;
            popped_q <= 1'b0;
        end else begin
            // Newer pipeline write kills older queued writes to the same rd.
            if (wb_grant) begin
                for (int i = 0; i < 2; i++) begin
                    if (q_rd[i] == wb_rd) q_live[i] <= 1'b0;
                end
            end
            if (pop) begin
                q_live[rd_ptr] <= 1'b0;
                rd_ptr         <= ~rd_ptr;
            end
            if (push) begin
                q_live[wr_ptr] <= (mdu_rd != 5'd0);
                wr_ptr         <= ~wr_ptr;
            end

            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase

            if (count == 2'd0 || pop) begin
                starve <= 4'd0;
            end else if (starve != 4'hF) begin
                starve <= starve + 4'd1;
            end

            // Stall persists through the cycle after the first pop.
            if (stall_q) begin
                if (popped_q) begin
                    stall_q  <= 1'b0;
                    popped_q <= 1'b0;
                end else if (pop) begin
                    popped_q <= 1'b1;
                end
            end else if (starve_hit) begin
                stall_q <= 1'b1;
            end
        end
    end

`ifdef RF_ARB_FWD_EN
    logic yng;
    logic old;

    assign yng = ~wr_ptr;
    assign old = wr_ptr;

    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = 32'd0;
        if (fwd_rs != 5'd0) begin
            if (q_live[yng] && q_rd[yng] == fwd_rs) begin
                fwd_hit  = 1'b1;
                fwd_data = q_data[yng];
            end else if (q_live[old] && q_rd[old] == fwd_rs) begin
                fwd_hit  = 1'b1;
                fwd_data = q_data[old];
            end
        end
    end
`else
    logic fwd_unused;

    assign fwd_unused = ^fwd_rs;
    assign fwd_hit    = 1'b0;
    assign fwd_data   = 32'd0;
`endif

endmodule

// File: tb/tb_rf_wport_arb.sv
// Bench for rf_wport_arb: per-cycle vector table plus a write scoreboard.
// Build with RF_ARB_FWD_EN defined to also expect forwarding hits.
module tb_rf_wport_arb;

`ifdef RF_ARB_FWD_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mdu_valid;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic        rf_wr;
    logic [4:0]  rf_wr_reg;
    logic [31:0] rf_wr_data;
    logic        wb_stall;
    logic [1:0]  pend_count;
    logic [4:0]  fwd_rs;
    logic        fwd_hit;
    logic [31:0] fwd_data;

    always #5 clk = ~clk;

    rf_wport_arb #(.STARVE_MAX(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .mdu_valid  (mdu_valid),
        .mdu_rd     (mdu_rd),
        .mdu_data   (mdu_data),
        .mdu_ready  (mdu_ready),
        .rf_wr      (rf_wr),
        .rf_wr_reg  (rf_wr_reg),
        .rf_wr_data (rf_wr_data),
        .wb_stall   (wb_stall),
        .pend_count (pend_count),
        .fwd_rs     (fwd_rs),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data)
    );

    typedef struct {
        logic        wv;
        logic [4:0]  wrd;
        logic [31:0] wd;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic [4:0]  fr;
        logic        e_wr;
        logic [4:0]  e_reg;
        logic [31:0] e_data;
        logic        e_stall;
        logic [1:0]  e_cnt;
        logic        e_rdy;
        logic        e_fh;
        logic [31:0] e_fd;
    } vec_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    vec_t        vecs[$];
    wr_t         exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          wr_seen = 0;
    logic [31:0] regs_m [32];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic av(
        logic wv, logic [4:0] wrd, logic [31:0] wd,
        logic mv, logic [4:0] mrd, logic [31:0] md,
        logic [4:0] fr,
        logic ewr, logic [4:0] ereg, logic [31:0] edata,
        logic est, logic [1:0] ecnt, logic erdy,
        logic efh, logic [31:0] efd
    );
        vecs.push_back('{wv, wrd, wd, mv, mrd, md, fr,
                         ewr, ereg, edata, est, ecnt, erdy,
                         efh, efd});
    endtask

    task automatic idle_in();
        wb_valid  = 1'b0;
        wb_rd     = 5'd0;
        wb_data   = 32'd0;
        mdu_valid = 1'b0;
        mdu_rd    = 5'd0;
        mdu_data  = 32'd0;
        fwd_rs    = 5'd0;
    endtask

    // Entered at posedge+1; drives, checks at negedge, returns at posedge+1.
    task automatic run_vecs(int lo, int hi);
        vec_t v;
        for (int i = lo; i < hi; i++) begin
            v = vecs[i];
            wb_valid  = v.wv;
            wb_rd     = v.wrd;
            wb_data   = v.wd;
            mdu_valid = v.mv;
            mdu_rd    = v.mrd;
            mdu_data  = v.md;
            fwd_rs    = v.fr;
            if (v.e_wr) exp_q.push_back('{v.e_reg, v.e_data});
            @(negedge clk);
            chk($sformatf("v%0d_rf_wr", i), rf_wr, v.e_wr);
            chk($sformatf("v%0d_reg", i), rf_wr_reg, v.e_reg);
            chk($sformatf("v%0d_data", i), rf_wr_data, v.e_data);
            chk($sformatf("v%0d_stall", i), wb_stall, v.e_stall);
            chk($sformatf("v%0d_count", i), pend_count, v.e_cnt);
            chk($sformatf("v%0d_ready", i), mdu_ready, v.e_rdy);
            chk($sformatf("v%0d_fhit", i), fwd_hit, v.e_fh);
            chk($sformatf("v%0d_fdata", i), fwd_data, v.e_fd);
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (!rst && rf_wr) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got rd=%0d data=%h expected no write",
                         rf_wr_reg, rf_wr_data);
            end else begin
                e = exp_q.pop_front();
                chk("sb_rd", rf_wr_reg, e.rd);
                chk("sb_data", rf_wr_data, e.data);
            end
            regs_m[rf_wr_reg] = rf_wr_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ws;
        rst = 1'b1;
        idle_in();

        // single push, idle pipeline
        av(0,0,0,      1,5,'hA5, 0, 0,0,0,       0,0,1, 0,0);
        av(0,0,0,      0,0,0,    0, 1,5,'hA5,    0,1,1, 0,0);
        av(0,0,0,      0,0,0,    0, 0,0,0,       0,0,1, 0,0);
        // starvation, stall, drain
        av(1,7,'h70,   1,10,'hB1, 0, 1,7,'h70,   0,0,1, 0,0);
        av(1,7,'h70,   1,11,'hB2, 0, 1,7,'h70,   0,1,1, 0,0);
        av(1,7,'h70,   1,12,'hB3, 0, 1,7,'h70,   0,2,0, 0,0);
        av(1,7,'h70,   1,12,'hB3, 0, 1,7,'h70,   0,2,0, 0,0);
        av(1,7,'h70,   1,12,'hB3, 0, 1,7,'h70,   0,2,0, 0,0);
        av(1,7,'h70,   0,0,0,    0, 1,10,'hB1,   1,2,0, 0,0);
        av(1,7,'h70,   0,0,0,    0, 1,11,'hB2,   1,1,1, 0,0);
        av(1,7,'h70,   0,0,0,    0, 1,7,'h70,    0,0,1, 0,0);
        av(0,0,0,      0,0,0,    0, 0,0,0,       0,0,1, 0,0);
        // WAW kill, then same-cycle push survives
        av(1,4,'h44,   1,3,'h33, 0, 1,4,'h44,    0,0,1, 0,0);
        av(1,3,'h11,   0,0,0,    0, 1,3,'h11,    0,1,1, 0,0);
        av(0,0,0,      0,0,0,    0, 0,0,0,       0,1,1, 0,0);
        av(0,0,0,      0,0,0,    0, 0,0,0,       0,0,1, 0,0);
        av(1,3,'h66,   1,3,'h55, 0, 1,3,'h66,    0,0,1, 0,0);
        av(0,0,0,      0,0,0,    0, 1,3,'h55,    0,1,1, 0,0);
        av(0,0,0,      0,0,0,    0, 0,0,0,       0,0,1, 0,0);
        // x0 destinations
        av(1,0,'h77,   1,0,'h99, 0, 0,0,0,       0,0,1, 0,0);
        av(0,0,0,      0,0,0,    0, 0,0,0,       0,1,1, 0,0);
        av(0,0,0,      0,0,0,    0, 0,0,0,       0,0,1, 0,0);
        // forwarding lookup
        av(1,7,'h70,   1,9,'h1,  0, 1,7,'h70,    0,0,1, 0,0);
        av(1,7,'h70,   1,9,'h2,  9, 1,7,'h70,    0,1,1, FE, FE ? 32'h1 : 32'h0);
        av(1,7,'h70,   0,0,0,    9, 1,7,'h70,    0,2,0, FE, FE ? 32'h2 : 32'h0);
        av(0,0,0,      0,0,0,    9, 1,9,'h1,     0,2,0, FE, FE ? 32'h2 : 32'h0);
        av(0,0,0,      0,0,0,    0, 1,9,'h2,     0,1,1, 0,0);
        av(0,0,0,      0,0,0,    9, 0,0,0,       0,0,1, 0,0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_count", pend_count, 0);
        chk("rst_ready", mdu_ready, 1);
        chk("rst_rf_wr", rf_wr, 0);
        chk("rst_stall", wb_stall, 0);
        chk("rst_fhit", fwd_hit, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_vecs(0, 16);
        chk("reg3_kept", regs_m[3], 32'h11);
        run_vecs(16, vecs.size());
        chk("sb_drained", exp_q.size(), 0);

        // reset with a full queue discards both entries
        wb_valid  = 1'b1;
        wb_rd     = 5'd7;
        wb_data   = 32'h70;
        mdu_valid = 1'b1;
        mdu_rd    = 5'd20;
        mdu_data  = 32'h1;
        exp_q.push_back('{5'd7, 32'h70});
        @(posedge clk);
        #1;
        mdu_rd   = 5'd21;
        mdu_data = 32'h2;
        exp_q.push_back('{5'd7, 32'h70});
        @(posedge clk);
        #1;
        chk("full_count", pend_count, 2);
        chk("full_ready", mdu_ready, 0);
        idle_in();
        rst = 1'b1;
        #1;
        chk("mid_rst_count", pend_count, 0);
        chk("mid_rst_ready", mdu_ready, 1);
        chk("mid_rst_rf_wr", rf_wr, 0);
        chk("mid_rst_stall", wb_stall, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ws = wr_seen;
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_writes", wr_seen, ws);
        chk("post_rst_count", pend_count, 0);
        chk("sb_final", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
